// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Purpose  : Shared encodings and default widths for the two-core memory
//            port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // Default widths, matching the core data word and address bus
    localparam int DEF_WORD_W = 8;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_CNT_W  = 16;

    // Requester / cache I/O state encoding (2'b11 is not a legal code)
    typedef enum logic [1:0] {
        IO_IDLE = 2'b00,
        IO_RD   = 2'b01,
        IO_WT   = 2'b10
    } io_state_t;

    localparam logic [1:0] IO_ILLEGAL = 2'b11;

    // Arbiter FSM state encoding
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY    = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    // A requester is asking for the port only on a read or a write
    function automatic logic is_request(input logic [1:0] rw);
        return (rw == IO_RD) || (rw == IO_WT);
    endfunction

    // The illegal code is reported but never treated as a request
    function automatic logic is_illegal(input logic [1:0] rw);
        return (rw == IO_ILLEGAL);
    endfunction

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick2
// Purpose  : Two-way round-robin winner selection. A sole requester wins;
//            on a tie the requester that was not granted last wins.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic winner
);

    // Pure combinational pick; the caller registers whatever it needs
    always_comb begin
        valid  = req0 | req1;
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one cache/memory port between two cores. Round-robin,
//            non-preemptive, one transaction in flight at a time. Each core
//            keeps its rw/addr/data/done handshake unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,

    // Core 0 side
    input  logic [1:0]        rw0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [WORD_W-1:0] wdata0,
    output logic              done0,
    output logic [WORD_W-1:0] rdata0,

    // Core 1 side
    input  logic [1:0]        rw1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [WORD_W-1:0] wdata1,
    output logic              done1,
    output logic [WORD_W-1:0] rdata1,

    // Cache side
    output logic [1:0]        rw_to_cache,
    output logic [ADDR_W-1:0] addr_to_cache,
    output logic [WORD_W-1:0] data_to_cache,
    input  logic              cache_en,
    input  logic [WORD_W-1:0] data_from_cache,

    // Status
    output logic              owner,
    output logic              busy,
    output logic              err,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    arb_state_t        state;

    logic              req0;
    logic              req1;
    logic              pick_valid;
    logic              pick_winner;

    logic [1:0]        win_rw;
    logic [ADDR_W-1:0] win_addr;
    logic [WORD_W-1:0] win_wdata;

    logic              in_busy;
    logic              illegal_seen;

    assign req0         = is_request(rw0);
    assign req1         = is_request(rw1);
    assign illegal_seen = is_illegal(rw0) | is_illegal(rw1);

    // The last grant index doubles as the round-robin pointer
    rr_pick2 u_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (owner),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    // Select the winning requester's command for capture at the grant edge
    always_comb begin
        win_rw    = rw0;
        win_addr  = addr0;
        win_wdata = wdata0;
        if (pick_winner) begin
            win_rw    = rw1;
            win_addr  = addr1;
            win_wdata = wdata1;
        end
    end

    // Arbiter FSM: grant in IDLE, hold the command in BUSY, one idle cycle in RELEASE
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ARB_IDLE;
            rw_to_cache   <= IO_IDLE;
            addr_to_cache <= '0;
            data_to_cache <= '0;
            owner         <= 1'b1;
            busy          <= 1'b0;
            grant_cnt0    <= '0;
            grant_cnt1    <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        rw_to_cache   <= win_rw;
                        addr_to_cache <= win_addr;
                        data_to_cache <= win_wdata;
                        owner         <= pick_winner;
                        busy          <= 1'b1;
                        state         <= ARB_BUSY;
                        // Statistics counters stick at all-ones instead of wrapping
                        if (!pick_winner && !(&grant_cnt0)) begin
                            grant_cnt0 <= grant_cnt0 + CNT_ONE;
                        end
                        if (pick_winner && !(&grant_cnt1)) begin
                            grant_cnt1 <= grant_cnt1 + CNT_ONE;
                        end
                    end
                end
                ARB_BUSY: begin
                    // Command is held untouched until the cache completes
                    if (cache_en) begin
                        rw_to_cache <= IO_IDLE;
                        busy        <= 1'b0;
                        state       <= ARB_RELEASE;
                    end
                end
                ARB_RELEASE: begin
                    // Gives the cache and the finishing core one idle cycle
                    state <= ARB_IDLE;
                end
                default: begin
                    state       <= ARB_IDLE;
                    rw_to_cache <= IO_IDLE;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flag for an illegal rw code from either core
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (illegal_seen) begin
            err <= 1'b1;
        end
    end

    // A reset cycle aborts the transaction, so no completion leaks out during it
    assign in_busy = (state == ARB_BUSY) && !reset;

    // Route completion and load data to the owner only; the other core sees zeros
    always_comb begin
        done0  = 1'b0;
        done1  = 1'b0;
        rdata0 = '0;
        rdata1 = '0;
        if (in_busy) begin
            if (owner) begin
                done1  = cache_en;
                rdata1 = data_from_cache;
            end else begin
                done0  = cache_en;
                rdata0 = data_from_cache;
            end
        end
    end

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed, table-driven bench for mem_port_arbiter with a few
//            hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] RD = 2'b01;
    localparam logic [1:0] WT = 2'b10;
    localparam logic [1:0] IL = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  rw0, rw1;
    logic [7:0]  addr0, addr1, wdata0, wdata1;
    logic        done0, done1;
    logic [7:0]  rdata0, rdata1;
    logic [1:0]  rw_to_cache;
    logic [7:0]  addr_to_cache, data_to_cache;
    logic        cache_en;
    logic [7:0]  data_from_cache;
    logic        owner, busy, err;
    logic [15:0] grant_cnt0, grant_cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WORD_W(8), .ADDR_W(8), .CNT_W(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .rw0             (rw0),
        .addr0           (addr0),
        .wdata0          (wdata0),
        .done0           (done0),
        .rdata0          (rdata0),
        .rw1             (rw1),
        .addr1           (addr1),
        .wdata1          (wdata1),
        .done1           (done1),
        .rdata1          (rdata1),
        .rw_to_cache     (rw_to_cache),
        .addr_to_cache   (addr_to_cache),
        .data_to_cache   (data_to_cache),
        .cache_en        (cache_en),
        .data_from_cache (data_from_cache),
        .owner           (owner),
        .busy            (busy),
        .err             (err),
        .grant_cnt0      (grant_cnt0),
        .grant_cnt1      (grant_cnt1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus and the outputs expected during that cycle
    typedef struct {
        logic        rst;
        logic [1:0]  rw0;
        logic [7:0]  a0;
        logic [7:0]  wd0;
        logic [1:0]  rw1;
        logic [7:0]  a1;
        logic [7:0]  wd1;
        logic        ce;
        logic [7:0]  dfc;
        logic [1:0]  e_rw;
        logic [7:0]  e_addr;
        logic [7:0]  e_data;
        logic        e_d0;
        logic        e_d1;
        logic [7:0]  e_r0;
        logic [7:0]  e_r1;
        logic        e_own;
        logic        e_busy;
        logic        e_err;
        logic [15:0] e_c0;
        logic [15:0] e_c1;
    } vec_t;

    vec_t vecs[15];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Single requester: grant one edge after the request, cache_en two cycles later
        vecs[0]  = '{1'b0, RD, 8'h10, 8'h00, ID, 8'h00, 8'h00, 1'b0, 8'h00,
                     ID, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[1]  = '{1'b0, RD, 8'h10, 8'h00, ID, 8'h00, 8'h00, 1'b0, 8'h00,
                     RD, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 16'd1, 16'd0};
        vecs[2]  = '{1'b0, RD, 8'h10, 8'h00, ID, 8'h00, 8'h00, 1'b0, 8'h00,
                     RD, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 16'd1, 16'd0};
        vecs[3]  = '{1'b0, RD, 8'h10, 8'h00, ID, 8'h00, 8'h00, 1'b1, 8'hA5,
                     RD, 8'h10, 8'h00, 1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0, 16'd1, 16'd0};
        vecs[4]  = '{1'b0, ID, 8'h10, 8'h00, ID, 8'h00, 8'h00, 1'b0, 8'h00,
                     ID, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0};
        vecs[5]  = '{1'b0, ID, 8'h10, 8'h00, ID, 8'h00, 8'h00, 1'b0, 8'h00,
                     ID, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0};
        // Simultaneous requests right after reset: core 0 first, RELEASE, then core 1
        vecs[6]  = '{1'b1, WT, 8'h01, 8'h11, RD, 8'h02, 8'h77, 1'b0, 8'h00,
                     ID, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0};
        vecs[7]  = '{1'b0, WT, 8'h01, 8'h11, RD, 8'h02, 8'h77, 1'b0, 8'h00,
                     ID, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[8]  = '{1'b0, WT, 8'h01, 8'h11, RD, 8'h02, 8'h77, 1'b0, 8'h00,
                     WT, 8'h01, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 16'd1, 16'd0};
        vecs[9]  = '{1'b0, WT, 8'h01, 8'h11, RD, 8'h02, 8'h77, 1'b1, 8'h5A,
                     WT, 8'h01, 8'h11, 1'b1, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0, 16'd1, 16'd0};
        vecs[10] = '{1'b0, ID, 8'h01, 8'h11, RD, 8'h02, 8'h77, 1'b0, 8'h00,
                     ID, 8'h01, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0};
        vecs[11] = '{1'b0, ID, 8'h01, 8'h11, RD, 8'h02, 8'h77, 1'b0, 8'h00,
                     ID, 8'h01, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0};
        vecs[12] = '{1'b0, ID, 8'h01, 8'h11, RD, 8'h02, 8'h77, 1'b0, 8'h00,
                     RD, 8'h02, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 16'd1, 16'd1};
        vecs[13] = '{1'b0, ID, 8'h01, 8'h11, RD, 8'h02, 8'h77, 1'b1, 8'hC3,
                     RD, 8'h02, 8'h77, 1'b0, 1'b1, 8'h00, 8'hC3, 1'b1, 1'b1, 1'b0, 16'd1, 16'd1};
        vecs[14] = '{1'b0, ID, 8'h01, 8'h11, ID, 8'h02, 8'h77, 1'b0, 8'h00,
                     ID, 8'h02, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 16'd1, 16'd1};

        reset = 1'b1;
        rw0 = ID; rw1 = ID; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        cache_en = 1'b0; data_from_cache = '0;
        repeat (2) @(negedge clk);

        // Table-driven cycles: drive at the falling edge, compare just after
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            reset = vecs[i].rst;
            rw0 = vecs[i].rw0; addr0 = vecs[i].a0; wdata0 = vecs[i].wd0;
            rw1 = vecs[i].rw1; addr1 = vecs[i].a1; wdata1 = vecs[i].wd1;
            cache_en = vecs[i].ce; data_from_cache = vecs[i].dfc;
            #1;
            chk($sformatf("v%0d rw_to_cache", i),   32'(rw_to_cache),   32'(vecs[i].e_rw));
            chk($sformatf("v%0d addr_to_cache", i), 32'(addr_to_cache), 32'(vecs[i].e_addr));
            chk($sformatf("v%0d data_to_cache", i), 32'(data_to_cache), 32'(vecs[i].e_data));
            chk($sformatf("v%0d done0", i),         32'(done0),         32'(vecs[i].e_d0));
            chk($sformatf("v%0d done1", i),         32'(done1),         32'(vecs[i].e_d1));
            chk($sformatf("v%0d rdata0", i),        32'(rdata0),        32'(vecs[i].e_r0));
            chk($sformatf("v%0d rdata1", i),        32'(rdata1),        32'(vecs[i].e_r1));
            chk($sformatf("v%0d owner", i),         32'(owner),         32'(vecs[i].e_own));
            chk($sformatf("v%0d busy", i),          32'(busy),          32'(vecs[i].e_busy));
            chk($sformatf("v%0d err", i),           32'(err),           32'(vecs[i].e_err));
            chk($sformatf("v%0d grant_cnt0", i),    32'(grant_cnt0),    32'(vecs[i].e_c0));
            chk($sformatf("v%0d grant_cnt1", i),    32'(grant_cnt1),    32'(vecs[i].e_c1));
        end

        // Fairness with continuous requests; addr1 changes during core 0's transaction
        @(negedge clk);
        reset = 1'b1; rw0 = ID; rw1 = ID; cache_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        rw0 = RD; addr0 = 8'h20; rw1 = RD; addr1 = 8'h30;
        for (int i = 0; i < 6; i++) begin
            int   n;
            logic exp_own;
            logic [7:0] exp_addr;
            exp_own  = i[0];
            exp_addr = exp_own ? 8'h31 : 8'h20;
            n = 0;
            while (busy !== 1'b1 && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk($sformatf("fair%0d grant_in_time", i), 32'(n < 20), 32'(1));
            chk($sformatf("fair%0d owner", i), 32'(owner), 32'(exp_own));
            chk($sformatf("fair%0d addr", i), 32'(addr_to_cache), 32'(exp_addr));
            if (i == 0) addr1 = 8'h31;
            @(negedge clk);
            #1;
            chk($sformatf("fair%0d addr_stable", i), 32'(addr_to_cache), 32'(exp_addr));
            cache_en = 1'b1; data_from_cache = 8'h40 + 8'(i);
            #1;
            chk($sformatf("fair%0d done_owner", i), 32'(exp_own ? done1 : done0), 32'(1));
            chk($sformatf("fair%0d done_other", i), 32'(exp_own ? done0 : done1), 32'(0));
            @(negedge clk);
            cache_en = 1'b0;
            #1;
            chk($sformatf("fair%0d released", i), 32'({busy, rw_to_cache}), 32'({1'b0, ID}));
        end
        chk("fair grant_cnt0", 32'(grant_cnt0), 32'(3));
        chk("fair grant_cnt1", 32'(grant_cnt1), 32'(3));
        rw0 = ID; rw1 = ID;

        // Reset while a transaction is in flight
        @(negedge clk);
        rw0 = RD; addr0 = 8'h44;
        @(negedge clk);
        #1;
        chk("rstmid busy_before", 32'(busy), 32'(1));
        chk("rstmid owner_before", 32'(owner), 32'(0));
        reset = 1'b1; rw0 = ID;
        #1;
        chk("rstmid done0_in_reset", 32'(done0), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rstmid rw_to_cache", 32'(rw_to_cache), 32'(ID));
        chk("rstmid busy", 32'(busy), 32'(0));
        chk("rstmid owner", 32'(owner), 32'(1));
        chk("rstmid grant_cnt0", 32'(grant_cnt0), 32'(0));
        chk("rstmid grant_cnt1", 32'(grant_cnt1), 32'(0));
        chk("rstmid dones", 32'({done0, done1}), 32'(0));

        // Illegal code on core 1: sticky err, core 0 still served, core 1 never granted
        rw1 = IL; rw0 = RD; addr0 = 8'h50;
        #1;
        chk("illegal err_before_edge", 32'(err), 32'(0));
        @(negedge clk);
        #1;
        chk("illegal err_set", 32'(err), 32'(1));
        chk("illegal grant_core0", 32'({busy, owner}), 32'({1'b1, 1'b0}));
        chk("illegal addr", 32'(addr_to_cache), 32'(8'h50));
        cache_en = 1'b1; data_from_cache = 8'h99;
        #1;
        chk("illegal done0", 32'(done0), 32'(1));
        chk("illegal rdata0", 32'(rdata0), 32'(8'h99));
        chk("illegal done1", 32'(done1), 32'(0));
        @(negedge clk);
        cache_en = 1'b0; rw0 = ID;
        repeat (4) @(negedge clk);
        #1;
        chk("illegal no_grant1", 32'(busy), 32'(0));
        chk("illegal grant_cnt1", 32'(grant_cnt1), 32'(0));
        chk("illegal grant_cnt0", 32'(grant_cnt0), 32'(1));
        rw1 = ID;
        @(negedge clk);
        #1;
        chk("illegal err_sticky", 32'(err), 32'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
